concat_serializer: RTL and testbench
====================================

# concat_serializer

Downstream stage for the 3-bit packed field words produced by the field-concatenation block. Accepts 3-bit words over a valid/ready handshake and buffers them in a small FIFO. Emits each word MSB-first as a serial bit stream, with optional even-parity bit and start/last framing flags. Downstream backpressure is honoured through a serial ready.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in words; power of two, minimum 2.
- PARITY_EN, 1: 1 appends an even-parity bit per word; 0 emits 3 data bits only.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_data  in  3  packed word, bit 2 transmitted first
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- ser_out  out  1  current serial bit
- ser_valid  out  1  ser_out valid
- ser_ready  in  1  downstream accepts ser_out this cycle
- ser_start  out  1  high with the first bit (bit 2) of a word
- ser_last  out  1  high with the final bit of a word (parity bit, or bit 0 if PARITY_EN=0)
- fifo_count  out  $clog2(DEPTH)+1  words currently buffered, excluding the word being shifted

## Operation
- Input push occurs when in_valid && in_ready at a rising edge.
- in_ready = (fifo_count < DEPTH). It is combinational from the registered count. There is no bypass: when full, in_ready stays low even if a pop occurs in the same cycle.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.
- Serial transfer occurs when ser_valid && ser_ready at a rising edge.
- FSM states:
  - IDLE: ser_valid=0. If fifo_count>0, pop the head into the shift register, compute parity = ^word, and go to B2.
  - B2 → B1 → B0: present bit 2, then bit 1, then bit 0. Advance only on a serial transfer.
  - PAR (PARITY_EN=1 only): present the parity bit.
  - On transfer of the last bit: if fifo_count>0, pop and go directly to B2 (no idle gap). Otherwise go to IDLE.
- Outputs in B2/B1/B0/PAR:
  - ser_valid=1.
  - ser_start=1 in B2 only.
  - ser_last=1 in PAR, or in B0 when PARITY_EN=0.
- While ser_ready=0, ser_out, ser_start and ser_last hold stable and the state does not advance.
- Parity is even: the 3 data bits plus the parity bit contain an even number of ones.

## Timing
- Reset values: ser_out=0, ser_valid=0, ser_start=0, ser_last=0, fifo_count=0, in_ready=1. FSM is in IDLE and the pointers are 0.
- Reset mid-frame: the partial word and all buffered words are discarded. Outputs take their reset values the cycle after the rst edge, with no trailing bits.
- rst dominates any push or pop in the same cycle.
- Latency, empty block:
  - Word handshaken at edge k.
  - Count becomes 1 after edge k.
  - FSM pops at edge k+1.
  - ser_valid=1 with bit 2 during the cycle after edge k+1.
- Throughput with ser_ready held high: 4 cycles per word (PARITY_EN=1), 3 cycles per word (PARITY_EN=0). Sustained input at that rate never fills the FIFO.
- Full FIFO: in_ready=0 until the edge after a pop reduces the count.
- Empty FIFO when the last bit transfers: ser_valid drops in the next cycle.

## Test plan
- Reset then single word: push 3'b101, ser_ready=1. Expect ser_out 1,0,1,0 on four consecutive cycles starting 2 cycles after the handshake. ser_start on the first bit, ser_last on the fourth. fifo_count returns to 0.
- Back-to-back words: push 3'b110, 3'b100, 3'b011 on consecutive cycles. Expect the continuous stream 1100 1001 0110 with no gap. ser_start pulses every 4 cycles.
- Backpressure and full: hold ser_ready=0 and push 5 words with DEPTH=4. Expect:
  - The first word is popped into the shifter.
  - fifo_count reaches 4 and in_ready=0 while the 6th word is offered.
  - ser_out is stable at bit 2 of word 1.
  - After ser_ready=1, all 5 words emerge in order.
- Intermittent ready: toggle ser_ready 1,0,1,0 during word 3'b111. Expect bits 1,1,1,1 with each bit held through ready-low cycles, and no bit duplicated or skipped.
- PARITY_EN=0: push 3'b010 and 3'b001. Expect 010 001 with ser_last on bit 0 of each word and 3 cycles per word.
- Mid-frame reset: assert rst during B1 of 3'b110 with 2 words buffered. Expect ser_valid=0 and fifo_count=0 the next cycle. A new push of 3'b001 then produces exactly 0,0,1,1.

Source files
------------

// File: rtl/concat_serializer_if.sv
// concat_serializer_if: handshake bundle for the 3-bit word serializer.
//   in_data/in_valid/in_ready      word input, valid/ready handshake
//   ser_out/ser_valid/ser_ready    serial bit output, valid/ready handshake
//   ser_start/ser_last             framing flags for the first/final bit of a word
//   fifo_count                     words buffered, excluding the word being shifted
// master: the side that supplies words and consumes bits; slave: the serializer.
interface concat_serializer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [2:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_start;
  logic          ser_last;
  logic [CW-1:0] fifo_count;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_start, ser_last, fifo_count
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_start, ser_last, fifo_count
  );
endinterface

// File: rtl/concat_serializer.sv
// concat_serializer: buffers 3-bit words in a small FIFO and emits each word MSB-first
// as a serial stream, optionally followed by an even-parity bit.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   concat_serializer_if.slave (word input, serial output, fifo_count)
// DEPTH must be a power of two (>= 2) and match the interface instance's DEPTH.
module concat_serializer #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  concat_serializer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {StIdle, StB2, StB1, StB0, StPar} state_e;

  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  state_e        state_q;
  logic [1:0]    shift_q;
  logic          parity_q;
  logic          ser_out_q, ser_valid_q, ser_start_q, ser_last_q;

  logic          in_ready;
  logic          push, pop, last_xfer;
  logic [2:0]    head;

  // No bypass: a full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign push      = bus.in_valid && in_ready;
  assign last_xfer = bus.ser_ready &&
                     ((state_q == StPar) || ((state_q == StB0) && !PARITY_EN));
  assign pop       = (count_q != '0) && ((state_q == StIdle) || last_xfer);
  assign head      = mem_q[rd_ptr_q];

  // Word storage; pointers carry the reset, so the data array needs none.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serializer FSM with registered outputs. The advance logic drops to idle on the
  // final bit; a pop in the same cycle then overrides that and starts the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_start_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StB2: begin
          if (bus.ser_ready) begin
            state_q     <= StB1;
            ser_out_q   <= shift_q[1];
            ser_start_q <= 1'b0;
          end
        end
        StB1: begin
          if (bus.ser_ready) begin
            state_q    <= StB0;
            ser_out_q  <= shift_q[0];
            ser_last_q <= !PARITY_EN;
          end
        end
        StB0: begin
          if (bus.ser_ready) begin
            if (PARITY_EN) begin
              state_q    <= StPar;
              ser_out_q  <= parity_q;
              ser_last_q <= 1'b1;
            end else begin
              state_q     <= StIdle;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              ser_last_q  <= 1'b0;
            end
          end
        end
        StPar: begin
          if (bus.ser_ready) begin
            state_q     <= StIdle;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_start_q <= 1'b0;
          ser_last_q  <= 1'b0;
        end
      endcase

      if (pop) begin
        state_q     <= StB2;
        shift_q     <= head[1:0];
        parity_q    <= ^head;
        ser_out_q   <= head[2];
        ser_valid_q <= 1'b1;
        ser_start_q <= 1'b1;
        ser_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_start  = ser_start_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_concat_serializer.sv
// tb_concat_serializer: table-driven check of concat_serializer with parity on and off.
module tb_concat_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  concat_serializer_if #(.DEPTH(4)) b0 ();
  concat_serializer_if #(.DEPTH(4)) b1 ();

  concat_serializer #(.DEPTH(4), .PARITY_EN(1'b1)) u_dut_par (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  concat_serializer #(.DEPTH(4), .PARITY_EN(1'b0)) u_dut_nopar (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // One row per cycle: inputs driven during the cycle, outputs expected during it.
  // exp = {ser_valid, ser_out, ser_start, ser_last, in_ready, fifo_count[2:0]}
  typedef struct {
    logic       iv;
    logic [2:0] d;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t tq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic iv, logic [2:0] d, logic rdy, logic v, logic o,
                              logic s, logic l, logic ir, logic [2:0] cnt);
    vec_t r;
    r.iv  = iv;
    r.d   = d;
    r.rdy = rdy;
    r.exp = {v, o, s, l, ir, cnt};
    return r;
  endfunction

  function automatic logic [7:0] obs(int sel);
    if (sel == 0)
      return {b0.ser_valid, b0.ser_out, b0.ser_start, b0.ser_last, b0.in_ready, b0.fifo_count};
    return {b1.ser_valid, b1.ser_out, b1.ser_start, b1.ser_last, b1.in_ready, b1.fifo_count};
  endfunction

  task automatic drive(int sel, logic iv, logic [2:0] d, logic rdy);
    if (sel == 0) begin
      b0.in_valid = iv; b0.in_data = d; b0.ser_ready = rdy;
    end else begin
      b1.in_valid = iv; b1.in_data = d; b1.ser_ready = rdy;
    end
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (valid out start last in_ready count)", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(string nm, int sel);
    foreach (tq[i]) begin
      drive(sel, tq[i].iv, tq[i].d, tq[i].rdy);
      chk($sformatf("%s[%0d]", nm, i), obs(sel), tq[i].exp);
      cyc();
    end
    tq.delete();
    drive(sel, 1'b0, 3'b000, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 3'b000, 1'b0);
    drive(1, 1'b0, 3'b000, 1'b0);
    cyc();
    cyc();
    chk("reset_par",   obs(0), 8'b0000_1_000);
    chk("reset_nopar", obs(1), 8'b0000_1_000);
    rst = 1'b0;

    // Single word 101, parity 0: bits 1,0,1,0 starting two cycles after the handshake.
    tq.push_back(mk(1, 3'b101, 1, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("single", 0);

    // Back-to-back 110,100,011: stream 1100 1001 0110 with no gap.
    tq.push_back(mk(1, 3'b110, 1, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(1, 3'b100, 1, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(1, 3'b011, 1, 1, 1, 1, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("b2b", 0);

    // Intermittent ready on 111 (parity 1): each bit held while ready is low.
    tq.push_back(mk(1, 3'b111, 0, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 0, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 0, 1, 1, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("toggle", 0);

    // Backpressure: 5 words with ready low fill the FIFO; a 6th (111) is refused.
    tq.push_back(mk(1, 3'b101, 0, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(1, 3'b011, 0, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(1, 3'b110, 0, 1, 1, 1, 0, 1, 1));
    tq.push_back(mk(1, 3'b001, 0, 1, 1, 1, 0, 1, 2));
    tq.push_back(mk(1, 3'b100, 0, 1, 1, 1, 0, 1, 3));
    tq.push_back(mk(1, 3'b111, 0, 1, 1, 1, 0, 0, 4));
    tq.push_back(mk(0, 3'b000, 0, 1, 1, 1, 0, 0, 4));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 0, 4));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 0, 4));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 0, 4));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 0, 4));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 3));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 3));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 3));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 3));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 2));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("full", 0);

    // No parity: 010 then 001, 3 cycles per word, last on bit 0.
    tq.push_back(mk(1, 3'b010, 1, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(1, 3'b001, 1, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("nopar", 1);

    // Mid-frame reset: reach B1 of 110 with two words buffered, then reset with a push
    // offered in the same cycle; nothing of the old frame or the offered word survives.
    drive(0, 1'b1, 3'b110, 1'b1);
    cyc();
    drive(0, 1'b1, 3'b101, 1'b1);
    cyc();
    drive(0, 1'b1, 3'b011, 1'b1);
    cyc();
    chk("pre_rst_b1", obs(0), 8'b1100_1_010);
    rst = 1'b1;
    drive(0, 1'b1, 3'b111, 1'b1);
    cyc();
    chk("post_rst", obs(0), 8'b0000_1_000);
    rst = 1'b0;
    drive(0, 1'b0, 3'b000, 1'b1);

    tq.push_back(mk(1, 3'b001, 1, 0, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 1));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 1, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 0, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 0, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 1, 1, 0, 1, 1, 0));
    tq.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 1, 0));
    run_q("after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
